// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// ALU_SEQ_CARRY_CHAIN_EN adds the carry helper used by the carry-chain build.
package alu_seq_pkg;

   localparam int ALU_DW    = 8;
   localparam int SEL_W     = 5;
   localparam int SEL_ARITH = 2;
   localparam logic [1:0] OP_ADDC = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam int CMD_W     = SEL_W + 2*ALU_DW + 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CAPT = 2'd2,
      OUT  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic [SEL_W-1:0]  sel;
      logic [ALU_DW-1:0] a;
      logic [ALU_DW-1:0] b;
      logic              cin;
      logic              chain;
   } alu_cmd_t;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
   // Carry-out of the ALU adder for Add/AddC; plain Add never consumes a carry-in.
   function automatic logic add_carry(input logic [SEL_W-1:0]  sel,
                                      input logic [ALU_DW-1:0] a,
                                      input logic [ALU_DW-1:0] b,
                                      input logic              cin_eff);
      logic [ALU_DW:0] sum;
      logic            cin_add;
      cin_add = (sel[1:0] == OP_ADD) ? 1'b0 : cin_eff;
      sum     = {1'b0, a} + {1'b0, b} + {{ALU_DW{1'b0}}, cin_add};
      if (sel[SEL_ARITH] && ((sel[1:0] == OP_ADDC) || (sel[1:0] == OP_ADD)))
         return sum[ALU_DW];
      return 1'b0;
   endfunction
`endif

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and result signals of the sequencer; slave is the sequencer side.
interface alu_op_sequencer_if #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [4:0]             cmd_sel;
   logic [DW-1:0]          cmd_a;
   logic [DW-1:0]          cmd_b;
   logic                   cmd_cin;
   logic                   cmd_chain;
   logic [DW-1:0]          alu_a;
   logic [DW-1:0]          alu_b;
   logic [4:0]             alu_sel;
   logic                   alu_cin;
   logic [DW-1:0]          alu_y;
   logic                   res_valid;
   logic                   res_ready;
   logic [DW-1:0]          res_data;
   logic                   res_carry;
   logic [$clog2(DEPTH):0] fifo_count;

   modport slave (
      input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_cin, cmd_chain, alu_y, res_ready,
      output cmd_ready, alu_a, alu_b, alu_sel, alu_cin, res_valid, res_data, res_carry,
             fifo_count
   );

   modport master (
      output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_cin, cmd_chain, alu_y, res_ready,
      input  cmd_ready, alu_a, alu_b, alu_sel, alu_cin, res_valid, res_data, res_carry,
             fifo_count
   );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; ready is registered from the next occupancy so it
// reads 0 while in reset and !full afterwards.
module alu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int CMD_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [CMD_W-1:0]       push_data,
   input  logic                   pop,
   output logic [CMD_W-1:0]       pop_data,
   output logic                   empty,
   output logic                   ready,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [CMD_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             ready_q, ready_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && ready_q;
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop)
         count_d = count_q + 1'b1;
      else if (!do_push && do_pop)
         count_d = count_q - 1'b1;
      ready_d  = (count_d != (AW+1)'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
      end
   end

   // Storage carries no reset so it maps onto plain RAM; stale entries are never read.
   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign empty    = (count_q == '0);
   assign ready    = ready_q;
   assign count    = count_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the registered 8-bit ALU: buffers commands, issues one at a time,
// returns each result. ALU_SEQ_CARRY_CHAIN_EN enables carry tracking and chaining.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = ALU_DW
) (
   input logic               clk,
   input logic               rst_n,
   alu_op_sequencer_if.slave bus
);
   seq_state_t             state_q, state_d;
   logic [DW-1:0]          alu_a_q, alu_a_d;
   logic [DW-1:0]          alu_b_q, alu_b_d;
   logic [4:0]             alu_sel_q, alu_sel_d;
   logic                   alu_cin_q, alu_cin_d;
   logic                   res_valid_q, res_valid_d;
   logic [DW-1:0]          res_data_q, res_data_d;

   alu_cmd_t               push_cmd, head_cmd;
   logic [CMD_W-1:0]       head_bits;
   logic                   fifo_empty, fifo_ready, push, pop;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   cin_eff;

   always_comb begin
      push_cmd.sel   = bus.cmd_sel;
      push_cmd.a     = bus.cmd_a;
      push_cmd.b     = bus.cmd_b;
      push_cmd.cin   = bus.cmd_cin;
      push_cmd.chain = bus.cmd_chain;
   end

   assign push     = bus.cmd_valid && fifo_ready;
   assign head_cmd = alu_cmd_t'(head_bits);

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .CMD_W (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_cmd),
      .pop       (pop),
      .pop_data  (head_bits),
      .empty     (fifo_empty),
      .ready     (fifo_ready),
      .count     (fifo_count)
   );

   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sel_d   = alu_sel_q;
      alu_cin_d   = alu_cin_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      pop         = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: state_d = CAPT;
         CAPT: begin
            res_data_d  = bus.alu_y;
            res_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            // The accepting edge doubles as the next issue edge to keep 3-cycle throughput.
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = EXEC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         alu_a_d   = head_cmd.a;
         alu_b_d   = head_cmd.b;
         alu_sel_d = head_cmd.sel;
         alu_cin_d = cin_eff;
      end
   end

`ifdef ALU_SEQ_CARRY_CHAIN_EN
   logic carry_q, carry_d;
   logic res_carry_q, res_carry_d;

   // Stored carry is consumed and replaced at the same pop, so a chained AddC
   // sees the carry of the command issued just before it.
   always_comb begin
      cin_eff     = head_cmd.chain ? carry_q : head_cmd.cin;
      carry_d     = carry_q;
      res_carry_d = res_carry_q;
      if (pop)
         carry_d = add_carry(head_cmd.sel, head_cmd.a, head_cmd.b, cin_eff);
      if (state_q == CAPT)
         res_carry_d = carry_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q     <= 1'b0;
         res_carry_q <= 1'b0;
      end else begin
         carry_q     <= carry_d;
         res_carry_q <= res_carry_d;
      end
   end

   assign bus.res_carry = res_carry_q;
`else
   logic unused_chain;
   assign cin_eff       = head_cmd.cin;
   assign unused_chain  = head_cmd.chain;
   assign bus.res_carry = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         alu_cin_q   <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         alu_cin_q   <= alu_cin_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign bus.cmd_ready  = fifo_ready;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_sel    = alu_sel_q;
   assign bus.alu_cin    = alu_cin_q;
   assign bus.res_valid  = res_valid_q;
   assign bus.res_data   = res_data_q;
   assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a registered ALU stub; expectations
// adapt to ALU_SEQ_CARRY_CHAIN_EN.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
   localparam bit CHAIN_EN = 1'b1;
`else
   localparam bit CHAIN_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_op_sequencer_if #(.DEPTH(4), .DW(8)) bus ();

   alu_op_sequencer #(.DEPTH(4), .DW(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ALU stub: arith 00 sub, 01 add+cin, 10 add, 11 inc; logic 00 and, 01 or,
   // 10 xor, 11 not; shift 01 shl, 10 shr, 11 rotate left.
   function automatic logic [7:0] alu_model(input logic [4:0] sel, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
      logic [7:0] base;
      if (sel[2]) begin
         case (sel[1:0])
            2'b00:   base = a - b;
            2'b01:   base = a + b + {7'd0, cin};
            2'b10:   base = a + b;
            default: base = a + 8'd1;
         endcase
      end else begin
         case (sel[1:0])
            2'b00:   base = a & b;
            2'b01:   base = a | b;
            2'b10:   base = a ^ b;
            default: base = ~a;
         endcase
      end
      case (sel[4:3])
         2'b01:   return {base[6:0], 1'b0};
         2'b10:   return {1'b0, base[7:1]};
         2'b11:   return {base[6:0], base[7]};
         default: return base;
      endcase
   endfunction

   always @(posedge clk) bus.alu_y <= alu_model(bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_cin);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input string tag, input logic [4:0] sel, input logic [7:0] a,
                           input logic [7:0] b, input logic cin, input logic chain);
      int n;
      bus.cmd_sel   = sel;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_cin   = cin;
      bus.cmd_chain = chain;
      bus.cmd_valid = 1'b1;
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      if (n >= 64) check({tag, "_push_tmo"}, 32'(bus.cmd_ready), 32'd1);
      tick();
      bus.cmd_valid = 1'b0;
      $display("PUSH %s sel=%05b a=%02h b=%02h cin=%0d chain=%0d", tag, sel, a, b, cin, chain);
   endtask

   task automatic wait_res(input string tag, input logic [7:0] exp_data, input logic exp_carry);
      int n;
      n = 0;
      while (bus.res_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, "_data"}, 32'(bus.res_data), 32'(exp_data));
      check({tag, "_carry"}, 32'(bus.res_carry), 32'(exp_carry));
      $display("RES  %s data=%02h carry=%0d", tag, bus.res_data, bus.res_carry);
      tick();
   endtask

   localparam logic [4:0] FILL_SEL [5] = '{5'b00110, 5'b00000, 5'b00010, 5'b01001, 5'b00100};
   localparam logic [7:0] FILL_A   [5] = '{8'h10, 8'hCF, 8'hAA, 8'h0F, 8'h05};
   localparam logic [7:0] FILL_B   [5] = '{8'h20, 8'h3C, 8'hFF, 8'h30, 8'h07};
   localparam logic [7:0] FILL_Y   [5] = '{8'h30, 8'h0C, 8'h55, 8'h7E, 8'hFE};
   localparam logic [7:0] WRAP_Y   [9] = '{8'h03, 8'h14, 8'h25, 8'h36, 8'h47,
                                           8'h58, 8'h69, 8'h7A, 8'h8B};

   initial begin
      int acc;
      int k;
      int seen;
      bit took;
      bit stable;

      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_sel   = '0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_cin   = 1'b0;
      bus.cmd_chain = 1'b0;
      bus.res_ready = 1'b1;

      // Reset state
      repeat (3) tick();
      check("rst_alu_a", 32'(bus.alu_a), 32'h0);
      check("rst_alu_sel", 32'(bus.alu_sel), 32'h0);
      check("rst_res_valid", 32'(bus.res_valid), 32'h0);
      check("rst_res_data", 32'(bus.res_data), 32'h0);
      check("rst_count", 32'(bus.fifo_count), 32'h0);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
      rst_n = 1'b1;
      tick();
      check("post_rst_ready", 32'(bus.cmd_ready), 32'h1);

      // Single command: edge timing through IDLE/EXEC/CAPT/OUT
      bus.cmd_sel   = 5'b00110;
      bus.cmd_a     = 8'h0F;
      bus.cmd_b     = 8'h01;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      check("single_count_e0", 32'(bus.fifo_count), 32'd1);
      tick();
      check("single_alu_a_e1", 32'(bus.alu_a), 32'h0F);
      check("single_alu_b_e1", 32'(bus.alu_b), 32'h01);
      check("single_alu_sel_e1", 32'(bus.alu_sel), 32'h06);
      check("single_count_e1", 32'(bus.fifo_count), 32'd0);
      tick();
      check("single_valid_e2", 32'(bus.res_valid), 32'h0);
      tick();
      check("single_valid_e3", 32'(bus.res_valid), 32'h1);
      check("single_data_e3", 32'(bus.res_data), 32'h10);
      check("single_carry_e3", 32'(bus.res_carry), 32'h0);
      $display("RES  single data=%02h carry=%0d", bus.res_data, bus.res_carry);
      tick();
      check("single_valid_e4", 32'(bus.res_valid), 32'h0);

      // Fill with results stalled: one command in flight plus DEPTH buffered
      bus.res_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         k = (acc < 5) ? acc : 4;
         bus.cmd_sel   = FILL_SEL[k];
         bus.cmd_a     = FILL_A[k];
         bus.cmd_b     = FILL_B[k];
         bus.cmd_cin   = 1'b0;
         bus.cmd_chain = 1'b0;
         bus.cmd_valid = 1'b1;
         took = bus.cmd_ready;
         tick();
         if (took) begin
            $display("PUSH fill%0d a=%02h b=%02h", acc, FILL_A[k], FILL_B[k]);
            acc++;
         end
      end
      bus.cmd_valid = 1'b0;
      check("fill_accepted", 32'(acc), 32'd5);
      check("fill_count", 32'(bus.fifo_count), 32'd4);
      check("fill_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("fill_res_valid", 32'(bus.res_valid), 32'd1);
      check("fill_res_data", 32'(bus.res_data), 32'h30);

      // Backpressure: OUT holds for 10 cycles with no pop
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h30 || bus.res_carry !== 1'b0 ||
             bus.fifo_count !== 3'd4 || bus.alu_a !== 8'h10)
            stable = 1'b0;
      end
      check("bp_stable", 32'(stable), 32'd1);
      bus.res_ready = 1'b1;
      tick();
      check("bp_release_alu_a", 32'(bus.alu_a), 32'hCF);
      check("bp_release_valid", 32'(bus.res_valid), 32'd0);
      check("bp_release_count", 32'(bus.fifo_count), 32'd3);
      check("bp_release_ready", 32'(bus.cmd_ready), 32'd1);
      for (int i = 1; i < 5; i++)
         wait_res($sformatf("fill%0d", i), FILL_Y[i], 1'b0);

      // Carry chain
      push_cmd("add_ff", 5'b00110, 8'hFF, 8'h01, 1'b0, 1'b0);
      wait_res("add_ff", 8'h00, CHAIN_EN);
      check("add_ff_cin", 32'(bus.alu_cin), 32'd0);
      push_cmd("addc_chain", 5'b00101, 8'h00, 8'h00, 1'b0, 1'b1);
      wait_res("addc_chain", CHAIN_EN ? 8'h01 : 8'h00, 1'b0);
      check("addc_chain_cin", 32'(bus.alu_cin), 32'(CHAIN_EN));
      push_cmd("addc_cin", 5'b00101, 8'hFF, 8'h00, 1'b1, 1'b0);
      wait_res("addc_cin", 8'h00, CHAIN_EN);
      check("addc_cin_cin", 32'(bus.alu_cin), 32'd1);
      push_cmd("add_nocin", 5'b00110, 8'h7F, 8'h80, 1'b1, 1'b1);
      wait_res("add_nocin", 8'hFF, 1'b0);
      check("add_nocin_cin", 32'(bus.alu_cin), 32'd1);

      // Reset in CAPT with a second command buffered
      push_cmd("rst_a", 5'b00110, 8'h77, 8'h01, 1'b0, 1'b0);
      push_cmd("rst_b", 5'b00110, 8'h66, 8'h01, 1'b0, 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_alu_a", 32'(bus.alu_a), 32'h0);
      check("midrst_alu_sel", 32'(bus.alu_sel), 32'h0);
      check("midrst_res_data", 32'(bus.res_data), 32'h0);
      check("midrst_res_valid", 32'(bus.res_valid), 32'h0);
      check("midrst_count", 32'(bus.fifo_count), 32'h0);
      check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.res_valid === 1'b1) seen++;
      end
      check("midrst_no_reissue", 32'(seen), 32'd0);
      check("midrst_alu_a_idle", 32'(bus.alu_a), 32'h0);

      // Wrap: 9 commands through the 4-deep FIFO, pushed and drained concurrently
      fork
         begin
            for (int i = 0; i < 9; i++)
               push_cmd($sformatf("wrap%0d", i), 5'b00110, 8'(8'h11 * i), 8'h03, 1'b0, 1'b0);
         end
         begin
            for (int j = 0; j < 9; j++)
               wait_res($sformatf("wrap%0d", j), WRAP_Y[j], 1'b0);
         end
      join
      repeat (4) tick();
      check("wrap_drained", 32'(bus.fifo_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
